// File: rtl/uart_resp_tx.sv
// Serialises one I2C read response into a fixed UART frame: HEADER, addr, data_hi, data_lo, plus an optional XOR checksum byte (UART_RESP_CHECKSUM_EN).
// Latency: tx drops to the start bit on the first clk edge after acceptance. Each byte is 8N1, LSB first, and bits are timed in sample_tick units.
// Backpressure: resp_ready is high only in IDLE. resp_valid is ignored while a frame is in flight, and nothing is queued.
module uart_resp_tx #(
   parameter int          SB_TICK = 16,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        resp_valid,
   output logic        resp_ready,
   input  logic [7:0]  resp_addr,
   input  logic [15:0] resp_data,
   output logic        tx,
   output logic        tx_busy,
   output logic        tx_done_tick
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Tick counter is wide enough for stop lengths up to 256 ticks.
   localparam int             TW       = 8;
   localparam logic [TW-1:0]  BIT_END  = TW'(15);
   localparam logic [TW-1:0]  STOP_END = TW'(SB_TICK - 1);
`ifdef UART_RESP_CHECKSUM_EN
   localparam logic [2:0]     LAST_BYTE = 3'd4;
`else
   localparam logic [2:0]     LAST_BYTE = 3'd3;
`endif

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      bit_q, bit_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      addr_q, addr_d;
   logic [15:0]     data_q, data_d;
   logic            tx_q, tx_d;
   logic [7:0]      byte_nxt;
   logic            accept;

   assign accept = resp_valid & resp_ready;
   assign tx     = tx_q;

   // Select the byte that follows the one currently indexed by idx_q. It is built from the captured copies only.
   always_comb begin
      byte_nxt = 8'h00;
      case (idx_q)
         3'd0:    byte_nxt = addr_q;
         3'd1:    byte_nxt = data_q[15:8];
         3'd2:    byte_nxt = data_q[7:0];
`ifdef UART_RESP_CHECKSUM_EN
         3'd3:    byte_nxt = addr_q ^ data_q[15:8] ^ data_q[7:0];
`endif
         default: byte_nxt = 8'h00;
      endcase
   end

   // State register. Reset returns to an idle line and clears all progress, so an aborted frame is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic. Counters and tx change only on sample_tick, except for acceptance in IDLE.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      addr_d  = addr_q;
      data_d  = data_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               tick_d  = '0;
               bit_d   = '0;
               idx_d   = '0;
               shreg_d = HEADER;
               addr_d  = resp_addr;
               data_d  = resp_data;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (sample_tick) begin
               if (tick_q == BIT_END) begin
                  state_d = DATA;
                  tick_d  = '0;
                  tx_d    = shreg_q[0];
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (sample_tick) begin
               if (tick_q == BIT_END) begin
                  tick_d = '0;
                  if (bit_q == 3'd7) begin
                     state_d = STOP;
                     bit_d   = '0;
                     tx_d    = 1'b1;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     shreg_d = {1'b0, shreg_q[7:1]};
                     tx_d    = shreg_q[1];
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (sample_tick) begin
               if (tick_q == STOP_END) begin
                  tick_d = '0;
                  if (idx_q == LAST_BYTE) begin
                     state_d = IDLE;
                     idx_d   = '0;
                  end else begin
                     // The next start bit follows the stop bit with no idle gap.
                     state_d = START;
                     idx_d   = idx_q + 3'd1;
                     shreg_d = byte_nxt;
                     tx_d    = 1'b0;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Status outputs. The done pulse is asserted in the same cycle as the final STOP->IDLE transition.
   always_comb begin
      resp_ready   = (state_q == IDLE);
      tx_busy      = (state_q != IDLE);
      tx_done_tick = (state_q == STOP) && sample_tick &&
                     (tick_q == STOP_END) && (idx_q == LAST_BYTE);
   end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx: default instance (SB_TICK=16) and a SB_TICK=32 instance.
module tb_uart_resp_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic        valid16, valid32;
   logic [7:0]  resp_addr;
   logic [15:0] resp_data;
   logic        rdy16, tx16, busy16, done16;
   logic        rdy32, tx32, busy32, done32;

   int checks   = 0;
   int failures = 0;
   int sel      = 0;
   int tick_period = 1;

`ifdef UART_RESP_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic [7:0] exp_b [0:4];
   logic       tx_m, busy_m, done_m, rdy_m;

   assign tx_m   = (sel != 0) ? tx32   : tx16;
   assign busy_m = (sel != 0) ? busy32 : busy16;
   assign done_m = (sel != 0) ? done32 : done16;
   assign rdy_m  = (sel != 0) ? rdy32  : rdy16;

   uart_resp_tx u_dut16 (
      .clk(clk), .reset(reset), .sample_tick(sample_tick),
      .resp_valid(valid16), .resp_ready(rdy16),
      .resp_addr(resp_addr), .resp_data(resp_data),
      .tx(tx16), .tx_busy(busy16), .tx_done_tick(done16)
   );

   uart_resp_tx #(.SB_TICK(32)) u_dut32 (
      .clk(clk), .reset(reset), .sample_tick(sample_tick),
      .resp_valid(valid32), .resp_ready(rdy32),
      .resp_addr(resp_addr), .resp_data(resp_data),
      .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32)
   );

   always #5 clk = ~clk;

   // sample_tick generator: updated just after each rising edge, one pulse every tick_period cycles.
   initial begin
      int tcnt;
      tcnt = 0;
      sample_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tcnt >= tick_period - 1) begin
            sample_tick = 1'b1;
            tcnt = 0;
         end else begin
            sample_tick = 1'b0;
            tcnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel != 0) valid32 = v;
      else          valid16 = v;
   endtask

   // Expected line level after t ticks have been consumed since acceptance.
   function automatic logic model_tx(input int t, input int bl);
      int b, pos;
      logic [7:0] v;
      b   = t / bl;
      pos = t % bl;
      if (pos < 16)   return 1'b0;
      if (pos >= 144) return 1'b1;
      v = exp_b[b];
      return v[(pos - 16) / 16];
   endfunction

   // Launch a frame and track it cycle by cycle against the tick-based model. Call this task at a negedge.
   task automatic run_frame(input int sb, input logic hold, input int exp_done, input logic chg,
                            input logic [7:0] a2, input logic [15:0] d2, input string tag);
      int bl, total, t, cyc, err, done_cyc, bit0_len, limit, pos;
      logic [7:0] got [0:4];
      logic exp_dn;
      bl = 144 + sb;
      total = NB * bl;
      limit = total * tick_period + 200;
      for (int i = 0; i < 5; i++) got[i] = 8'h00;
      t = 0; cyc = 0; err = 0; done_cyc = -1; bit0_len = 0;
      chk({tag, "_rdy_pre"}, {31'd0, rdy_m}, 32'd1);
      set_valid(1'b1);
      @(posedge clk);
      while (t < total && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_tx_lat1"}, {31'd0, tx_m}, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
            chk({tag, "_rdy_busy"}, {31'd0, rdy_m}, 32'd0);
            if (!hold) set_valid(1'b0);
         end
         if (chg && cyc == 100) begin
            resp_addr = a2;
            resp_data = d2;
         end
         if (tx_m !== model_tx(t, bl)) err++;
         if (busy_m !== 1'b1) err++;
         if (rdy_m !== 1'b0) err++;
         exp_dn = sample_tick && (t == total - 1);
         if (done_m !== exp_dn) err++;
         if (done_m === 1'b1) done_cyc = cyc;
         if (t >= 16 && t < 32) bit0_len++;
         pos = t % bl;
         if (pos >= 16 && pos < 144 && (pos % 16) == 8) got[t / bl][(pos - 16) / 16] = tx_m;
         if (sample_tick) t++;
      end
      chk({tag, "_ticks"}, t, total);
      chk({tag, "_cycle_err"}, err, 0);
      chk({tag, "_bit_len"}, bit0_len, 16 * tick_period);
      if (exp_done >= 0) chk({tag, "_done_cyc"}, done_cyc, exp_done);
      for (int i = 0; i < NB; i++) chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_b[i]});
      @(negedge clk);
      chk({tag, "_tx_idle"}, {31'd0, tx_m}, 32'd1);
      chk({tag, "_busy_idle"}, {31'd0, busy_m}, 32'd0);
      chk({tag, "_rdy_after"}, {31'd0, rdy_m}, 32'd1);
      chk({tag, "_done_low"}, {31'd0, done_m}, 32'd0);
   endtask

   initial begin
      int nd, nl, nb;
      reset = 1'b1; valid16 = 1'b0; valid32 = 1'b0;
      resp_addr = 8'h00; resp_data = 16'h0000;
      #1;
      chk("rst_tx", {31'd0, tx16}, 32'd1);
      chk("rst_busy", {31'd0, busy16}, 32'd0);
      chk("rst_done", {31'd0, done16}, 32'd0);
      chk("rst_rdy", {31'd0, rdy16}, 32'd1);
      chk("rst_tx32", {31'd0, tx32}, 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Basic frame, ticking every cycle.
      sel = 0;
      resp_addr = 8'h05; resp_data = 16'h1234;
      exp_b[0] = 8'hA5; exp_b[1] = 8'h05; exp_b[2] = 8'h12; exp_b[3] = 8'h34; exp_b[4] = 8'h23;
      run_frame(16, 1'b0, NB * 160, 1'b0, 8'h00, 16'h0000, "basic");

      // resp_valid held through the frame while the inputs change mid-frame.
      resp_addr = 8'h5A; resp_data = 16'hC3F0;
      exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'hC3; exp_b[3] = 8'hF0; exp_b[4] = 8'h69;
      run_frame(16, 1'b1, NB * 160, 1'b1, 8'h3C, 16'h0F81, "hold1");
      exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h0F; exp_b[3] = 8'h81; exp_b[4] = 8'hB2;
      run_frame(16, 1'b0, NB * 160, 1'b0, 8'h00, 16'h0000, "hold2");

      // Slow ticks: one sample_tick every 4 cycles.
      tick_period = 4;
      resp_addr = 8'h81; resp_data = 16'h7E00;
      exp_b[0] = 8'hA5; exp_b[1] = 8'h81; exp_b[2] = 8'h7E; exp_b[3] = 8'h00; exp_b[4] = 8'hFF;
      run_frame(16, 1'b0, -1, 1'b0, 8'h00, 16'h0000, "div4");
      tick_period = 1;
      repeat (4) @(negedge clk);

      // Two stop-bit instance.
      sel = 1;
      resp_addr = 8'h05; resp_data = 16'h1234;
      exp_b[0] = 8'hA5; exp_b[1] = 8'h05; exp_b[2] = 8'h12; exp_b[3] = 8'h34; exp_b[4] = 8'h23;
      run_frame(32, 1'b0, NB * 176, 1'b0, 8'h00, 16'h0000, "sb32");

      // Reset during the data bits of the second byte.
      sel = 0;
      valid16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid16 = 1'b0;
      repeat (230) @(negedge clk);
      chk("abort_busy_pre", {31'd0, busy16}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_tx", {31'd0, tx16}, 32'd1);
      chk("abort_busy", {31'd0, busy16}, 32'd0);
      chk("abort_done", {31'd0, done16}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_rdy", {31'd0, rdy16}, 32'd1);
      nd = 0; nl = 0; nb = 0;
      for (int i = 0; i < 900; i++) begin
         @(negedge clk);
         if (done16 !== 1'b0) nd++;
         if (tx16 !== 1'b1) nl++;
         if (busy16 !== 1'b0) nb++;
      end
      chk("abort_no_done", nd, 0);
      chk("abort_tx_high", nl, 0);
      chk("abort_no_resume", nb, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
